gamate_cart_fetch: RTL

//  Cartridge ROM fetch stage sitting directly upstream of the Gamate core's

---
 rtl/gamate_cart_fetch.sv | 99 +++++++++
 1 files changed

// File: rtl/gamate_cart_fetch.sv
// gamate_cart_fetch: cart ROM fetch with word cache, address mirroring and SDRAM keep-alive reads
module gamate_cart_fetch #(
  parameter logic [24:0] BASE_ADDR = 25'h0,
  parameter int          KEEPALIVE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] rom_addr,
  input  logic        rom_read,
  input  logic [21:0] rom_size,
  output logic [7:0]  cart_dout,
  output logic [24:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic [15:0] sdram_dout,
  output logic        busy
);
  localparam int KW = KEEPALIVE > 1 ? $clog2(KEEPALIVE) : 1;
  localparam logic [KW-1:0] KA_MAX = KW'(KEEPALIVE - 1);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, DRAIN} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] ka_q, ka_d;
  logic [20:0] tag_q, tag_d;
  logic [15:0] word_q, word_d;
  logic [7:0] cart_q, cart_d;
  logic [24:0] addr_q, addr_d;
  logic valid_q, valid_d, sel_q, sel_d, req_q, req_d;
  logic [21:0] mask, eff;
  logic oor, hit, ack_ok;
  always_comb begin
    mask = rom_size - 22'd1;
    mask = mask | (mask >> 1);
    mask = mask | (mask >> 2);
    mask = mask | (mask >> 4);
    mask = mask | (mask >> 8);
    mask = mask | (mask >> 16);
    eff = rom_addr & mask;
    oor = rom_size == 22'd0 || eff >= rom_size;
    hit = valid_q && eff[21:1] == tag_q && ka_q != KA_MAX;
    ack_ok = sdram_ack == req_q;
    state_d = state_q;
    ka_d = ka_q;
    tag_d = tag_q;
    word_d = word_q;
    cart_d = cart_q;
    addr_d = addr_q;
    valid_d = valid_q;
    sel_d = sel_q;
    req_d = req_q;
    if (reset) begin
      // an in-flight request must still be acked before the next toggle, so reset drains it
      state_d = state_q == IDLE ? IDLE : DRAIN;
      ka_d = '0;
      tag_d = '0;
      valid_d = 1'b0;
      sel_d = 1'b0;
      cart_d = 8'hFF;
      addr_d = BASE_ADDR;
    end else if (state_q == IDLE) begin
      ka_d = ka_q == KA_MAX ? ka_q : ka_q + KW'(1);
      if (rom_read && oor) begin
        cart_d = 8'hFF;
      end else if (rom_read && hit) begin
        cart_d = eff[0] ? word_q[15:8] : word_q[7:0];
      end else if (rom_read) begin
        addr_d = BASE_ADDR + 25'({eff[21:1], 1'b0});
        req_d = ~req_q;
        tag_d = eff[21:1];
        sel_d = eff[0];
        ka_d = '0;
        state_d = WAIT_ACK;
      end
    end else if (state_q == WAIT_ACK) begin
      if (ack_ok) begin
        word_d = sdram_dout;
        valid_d = 1'b1;
        cart_d = sel_q ? sdram_dout[15:8] : sdram_dout[7:0];
        state_d = IDLE;
      end
    end else begin
      state_d = ack_ok ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ka_q <= ka_d;
    tag_q <= tag_d;
    word_q <= word_d;
    cart_q <= cart_d;
    addr_q <= addr_d;
    valid_q <= valid_d;
    sel_q <= sel_d;
    req_q <= req_d;
  end
  assign cart_dout = cart_q;
  assign sdram_addr = addr_q;
  assign sdram_req = req_q;
  assign busy = state_q != IDLE;
endmodule
